// File: rtl/spi_sram_bridge_if.sv
// Signal bundle between the bridge and its SPI byte port, CoCo bus and SRAM pins.
interface spi_sram_bridge_if #(
  parameter int ADDR_W    = 16,
  parameter int NUM_BANKS = 2
);
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int LOW_W     = ADDR_W - BANK_BITS;

  logic                 spi_rx_valid;
  logic [7:0]           spi_rx_data;
  logic                 spi_tx_load;
  logic [7:0]           spi_tx_data;
  logic [LOW_W-1:0]     c_addr;
  logic [BANK_BITS-1:0] c_bank;
  logic                 c_sel;
  logic                 c_rw;
  logic                 c_halt_req;
  logic                 c_halt_ack;
  logic [LOW_W-1:0]     m_addr;
  logic [NUM_BANKS-1:0] m_cs_n;
  logic                 m_oe_n;
  logic                 m_we_n;
  logic [7:0]           m_dout;
  logic                 m_dout_en;
  logic [7:0]           m_din;
  logic                 spi_control;

  modport slave (
    input  spi_rx_valid, spi_rx_data, c_addr, c_bank, c_sel, c_rw, c_halt_ack, m_din,
    output spi_tx_load, spi_tx_data, c_halt_req, m_addr, m_cs_n, m_oe_n, m_we_n,
           m_dout, m_dout_en, spi_control
  );

  modport master (
    output spi_rx_valid, spi_rx_data, c_addr, c_bank, c_sel, c_rw, c_halt_ack, m_din,
    input  spi_tx_load, spi_tx_data, c_halt_req, m_addr, m_cs_n, m_oe_n, m_we_n,
           m_dout, m_dout_en, spi_control
  );
endinterface

// File: rtl/spi_sram_bridge.sv
// SPI-to-SRAM bridge: byte commands from the SPI slave drive counted SRAM bursts
// once the CoCo has been halted; otherwise the CoCo bus passes straight through.
module spi_sram_bridge #(
  parameter int ADDR_W    = 16,
  parameter int NUM_BANKS = 2,
  parameter int WR_PULSE  = 6,
  parameter int RD_WAIT   = 3
) (
  input logic              clock_50,
  input logic              reset,
  spi_sram_bridge_if.slave bus
);
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int LOW_W     = ADDR_W - BANK_BITS;
  localparam int AB        = (ADDR_W + 7) / 8;
  localparam int TMR_W     = $clog2(WR_PULSE + RD_WAIT + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, WCNT, WDATA, WPULSE, WHOLD, RCNT, RFETCH, RDUMMY, ACQ
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        count_q, count_d;
  logic              err_q, err_d;
  logic              ctl_q, ctl_d;
  logic              halt_q, halt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [7:0]        dout_q, dout_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_load_q, tx_load_d;
  logic              mem_cs, mem_oe, mem_we, mem_den;
  logic              rx;
  logic [7:0]        rx_byte;

  assign rx      = bus.spi_rx_valid;
  assign rx_byte = bus.spi_rx_data;

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      ctl_q     <= 1'b0;
      halt_q    <= 1'b0;
      tmr_q     <= '0;
      bcnt_q    <= '0;
      dout_q    <= '0;
      tx_data_q <= '0;
      tx_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      ctl_q     <= ctl_d;
      halt_q    <= halt_d;
      tmr_q     <= tmr_d;
      bcnt_q    <= bcnt_d;
      dout_q    <= dout_d;
      tx_data_q <= tx_data_d;
      tx_load_q <= tx_load_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    err_d     = err_q;
    ctl_d     = ctl_q;
    halt_d    = halt_q;
    tmr_d     = tmr_q;
    bcnt_d    = bcnt_q;
    dout_d    = dout_q;
    tx_data_d = tx_data_q;
    tx_load_d = 1'b0;
    mem_cs    = 1'b0;
    mem_oe    = 1'b0;
    mem_we    = 1'b0;
    mem_den   = 1'b0;
    unique case (state_q)
      IDLE: if (rx) begin
        case (rx_byte)
          8'h01: begin state_d = ADDR; bcnt_d = '0; end
          8'h02: state_d = WCNT;
          8'h03: state_d = RCNT;
          8'h04: begin state_d = ACQ; halt_d = 1'b1; end
          8'h05: begin ctl_d = 1'b0; halt_d = 1'b0; end
          8'h06: begin
            tx_data_d = {ctl_q, halt_q, err_q, 5'b0};
            tx_load_d = 1'b1;
            err_d     = 1'b0;
          end
          default: ;
        endcase
      end
      ADDR: if (rx) begin
        addr_d = {addr_q[ADDR_W-9:0], rx_byte};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'(AB - 1)) state_d = IDLE;
      end
      WCNT, RCNT: if (rx) begin
        count_d = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
        tmr_d   = '0;
        state_d = (state_q == WCNT) ? WDATA : RFETCH;
      end
      WDATA: if (rx) begin
        count_d = count_q - 9'd1;
        if (ctl_q) begin
          mem_cs  = 1'b1;
          dout_d  = rx_byte;
          tmr_d   = '0;
          state_d = WPULSE;
        end else begin
          err_d = 1'b1;
          if (count_q == 9'd1) state_d = IDLE;
        end
      end
      // Bytes landing inside a pulse are lost but still consume the burst count.
      WPULSE, WHOLD: begin
        mem_cs  = 1'b1;
        mem_den = 1'b1;
        if (rx) begin
          err_d = 1'b1;
          if (count_q != 9'd0) count_d = count_q - 9'd1;
        end
        if (state_q == WPULSE) begin
          mem_we = 1'b1;
          tmr_d  = tmr_q + TMR_W'(1);
          if (tmr_q == TMR_W'(WR_PULSE - 1)) state_d = WHOLD;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = (count_d == 9'd0) ? IDLE : WDATA;
        end
      end
      RFETCH: begin
        if (!ctl_q) begin
          tx_data_d = 8'hFF;
          tx_load_d = 1'b1;
          err_d     = 1'b1;
          state_d   = RDUMMY;
        end else begin
          mem_cs = 1'b1;
          mem_oe = 1'b1;
          tmr_d  = tmr_q + TMR_W'(1);
          if (tmr_q == TMR_W'(RD_WAIT - 1)) begin
            tx_data_d = bus.m_din;
            tx_load_d = 1'b1;
            state_d   = RDUMMY;
          end
        end
        // An early byte counts as the dummy: skip this fetch and advance.
        if (rx) begin
          err_d     = 1'b1;
          tx_data_d = tx_data_q;
          tx_load_d = 1'b0;
          addr_d    = addr_q + ADDR_W'(1);
          count_d   = count_q - 9'd1;
          tmr_d     = '0;
          state_d   = (count_q == 9'd1) ? IDLE : RFETCH;
        end
      end
      RDUMMY: if (rx) begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q - 9'd1;
        tmr_d   = '0;
        state_d = (count_q == 9'd1) ? IDLE : RFETCH;
      end
      ACQ: begin
        if (rx) err_d = 1'b1;
        if (bus.c_halt_ack && !bus.c_sel) begin
          ctl_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [NUM_BANKS-1:0] cs_n;
  logic [LOW_W-1:0]     maddr;
  logic                 oe_n, we_n, den;

  always_comb begin
    cs_n = '1;
    if (ctl_q) begin
      maddr = addr_q[LOW_W-1:0];
      if (mem_cs) cs_n[addr_q[ADDR_W-1 -: BANK_BITS]] = 1'b0;
      oe_n  = ~mem_oe;
      we_n  = ~mem_we;
      den   = mem_den;
    end else begin
      maddr              = bus.c_addr;
      cs_n[bus.c_bank]   = ~bus.c_sel;
      oe_n               = ~(bus.c_sel & bus.c_rw);
      we_n               = 1'b1;
      den                = 1'b0;
    end
  end

  assign bus.m_addr      = maddr;
  assign bus.m_cs_n      = cs_n;
  assign bus.m_oe_n      = oe_n;
  assign bus.m_we_n      = we_n;
  assign bus.m_dout      = dout_q;
  assign bus.m_dout_en   = den;
  assign bus.spi_tx_data = tx_data_q;
  assign bus.spi_tx_load = tx_load_q;
  assign bus.c_halt_req  = halt_q;
  assign bus.spi_control = ctl_q;
endmodule

// File: tb/tb_spi_sram_bridge.sv
// Self-checking bench for spi_sram_bridge: SRAM model plus scoreboard queues for
// SPI transmit bytes and SRAM write pulses.
module tb_spi_sram_bridge;
  logic clock_50 = 1'b0;
  logic reset    = 1'b0;
  always #10 clock_50 = ~clock_50;

  spi_sram_bridge_if #(.ADDR_W(16), .NUM_BANKS(2)) bus ();

  spi_sram_bridge #(
    .ADDR_W(16), .NUM_BANKS(2), .WR_PULSE(6), .RD_WAIT(3)
  ) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .bus      (bus.slave)
  );

  typedef struct {
    logic [14:0] addr;
    logic [1:0]  cs_n;
    logic [7:0]  data;
    int          width;
  } wr_t;

  logic [7:0] exp_tx[$];
  wr_t        exp_wr[$];
  logic [7:0] mem [0:65535];
  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SRAM model: bank bit recovered from the two-bank chip selects.
  always_comb begin
    bus.m_din = 8'h00;
    if (!bus.m_oe_n && bus.m_cs_n != 2'b11) bus.m_din = mem[{bus.m_cs_n[0], bus.m_addr}];
  end

  int          low_cnt = 0;
  logic [14:0] cap_addr;
  logic [1:0]  cap_cs;
  logic [7:0]  cap_data;

  always @(negedge clock_50) begin
    if (bus.spi_tx_load) begin
      if (exp_tx.size() == 0) check("tx_unexpected", 32'(bus.spi_tx_data), 32'hFFFF_FFFF);
      else check("tx_data", 32'(bus.spi_tx_data), 32'(exp_tx.pop_front()));
    end
    if (!bus.m_we_n) begin
      if (low_cnt == 0) begin
        cap_addr = bus.m_addr;
        cap_cs   = bus.m_cs_n;
        cap_data = bus.m_dout;
      end
      low_cnt++;
    end else if (low_cnt != 0) begin
      if (exp_wr.size() == 0) check("wr_unexpected", 32'(low_cnt), 32'hFFFF_FFFF);
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", 32'(cap_addr), 32'(e.addr));
        check("wr_cs_n", 32'(cap_cs), 32'(e.cs_n));
        check("wr_data", 32'(cap_data), 32'(e.data));
        check("wr_width", 32'(low_cnt), 32'(e.width));
      end
      mem[{cap_cs[0], cap_addr}] = cap_data;
      wr_count++;
      low_cnt = 0;
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    @(posedge clock_50); #1;
    bus.spi_rx_valid = 1'b1;
    bus.spi_rx_data  = b;
    @(posedge clock_50); #1;
    bus.spi_rx_valid = 1'b0;
    repeat (gap) @(posedge clock_50);
  endtask

  task automatic push_wr(input logic [14:0] a, input logic [1:0] cs, input logic [7:0] d,
                         input int w);
    wr_t e;
    e.addr = a; e.cs_n = cs; e.data = d; e.width = w;
    exp_wr.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wr_before;
    int bad;
    bus.spi_rx_valid = 1'b0;
    bus.spi_rx_data  = 8'h00;
    bus.c_addr       = 15'h0123;
    bus.c_bank       = 1'b1;
    bus.c_sel        = 1'b1;
    bus.c_rw         = 1'b1;
    bus.c_halt_ack   = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFF] = 8'h5A;
    mem[16'h0000] = 8'hA5;

    // Reset values and CoCo pass-through
    repeat (3) @(negedge clock_50);
    check("rst_spi_control", 32'(bus.spi_control), 32'd0);
    check("rst_halt_req", 32'(bus.c_halt_req), 32'd0);
    check("rst_tx_load", 32'(bus.spi_tx_load), 32'd0);
    check("rst_tx_data", 32'(bus.spi_tx_data), 32'd0);
    check("rst_we_n", 32'(bus.m_we_n), 32'd1);
    check("rst_dout_en", 32'(bus.m_dout_en), 32'd0);
    check("pass_cs_n", 32'(bus.m_cs_n), 32'h1);
    check("pass_oe_n", 32'(bus.m_oe_n), 32'd0);
    check("pass_addr", 32'(bus.m_addr), 32'h0123);
    @(posedge clock_50); #1;
    reset = 1'b1;

    // Write without bus ownership: discarded, error flagged
    wr_before = wr_count;
    send(8'h02, 0);
    send(8'h01, 0);
    send(8'h77, 10);
    check("noctl_no_write", 32'(wr_count - wr_before), 32'd0);
    exp_tx.push_back(8'h20);
    send(8'h06, 5);

    // Acquire
    bus.c_sel = 1'b0;
    send(8'h04, 0);
    bad = 0;
    repeat (50) begin
      @(negedge clock_50);
      if (bus.spi_control !== 1'b0 || bus.c_halt_req !== 1'b1) bad++;
    end
    check("acq_hold_cycles", 32'(bad), 32'd0);
    @(posedge clock_50); #1;
    bus.c_halt_ack = 1'b1;
    n = 0;
    do begin @(negedge clock_50); n++; end while (!bus.spi_control && n < 2);
    check("acq_granted", 32'(bus.spi_control), 32'd1);

    // Write burst at 0x8010
    send(8'h01, 0); send(8'h80, 0); send(8'h10, 0);
    send(8'h02, 0); send(8'h03, 0);
    push_wr(15'h0010, 2'b01, 8'hAA, 6);
    push_wr(15'h0011, 2'b01, 8'hBB, 6);
    push_wr(15'h0012, 2'b01, 8'hCC, 6);
    send(8'hAA, 20); send(8'hBB, 20); send(8'hCC, 20);
    check("wr_pending", 32'(exp_wr.size()), 32'd0);
    @(negedge clock_50);
    check("wr_final_addr", 32'(bus.m_addr), 32'h0013);

    // Read burst across the wrap at 0xFFFF
    send(8'h01, 0); send(8'hFF, 0); send(8'hFF, 0);
    exp_tx.push_back(8'h5A);
    send(8'h03, 0); send(8'h02, 10);
    exp_tx.push_back(8'hA5);
    send(8'h00, 0);
    @(negedge clock_50);
    check("rd_wrap_addr", 32'(bus.m_addr), 32'h0000);
    check("rd_wrap_cs_n", 32'(bus.m_cs_n), 32'h2);
    check("rd_wrap_oe_n", 32'(bus.m_oe_n), 32'd0);
    repeat (10) @(posedge clock_50);
    send(8'h00, 5);
    check("rd_pending", 32'(exp_tx.size()), 32'd0);

    // Overrun: second byte inside the first pulse
    send(8'h01, 0); send(8'h80, 0); send(8'h20, 0);
    send(8'h02, 0); send(8'h02, 0);
    wr_before = wr_count;
    push_wr(15'h0020, 2'b01, 8'h11, 6);
    send(8'h11, 0);
    send(8'h22, 20);
    check("ovr_one_write", 32'(wr_count - wr_before), 32'd1);
    exp_tx.push_back(8'hE0);
    send(8'h06, 5);
    exp_tx.push_back(8'hC0);
    send(8'h06, 5);

    // Reset in the middle of a write pulse
    send(8'h01, 0); send(8'h00, 0); send(8'h40, 0);
    send(8'h02, 0); send(8'h01, 0);
    push_wr(15'h0040, 2'b10, 8'h99, 3);
    send(8'h99, 0);
    check("abort_pulse_started", 32'(bus.m_we_n), 32'd0);
    repeat (3) @(negedge clock_50);
    #2;
    reset = 1'b0;
    #1;
    check("abort_we_n", 32'(bus.m_we_n), 32'd1);
    check("abort_spi_control", 32'(bus.spi_control), 32'd0);
    check("abort_halt_req", 32'(bus.c_halt_req), 32'd0);
    repeat (3) @(posedge clock_50);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clock_50);

    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/spi_sram_bridge.md
Name: spi_sram_bridge

Overview:
- Next-generation SPI-to-SRAM bridge for the CoCo cartridge. An SPI master loads, inspects and patches cartridge SRAM through it while the CoCo is held off the bus.
- Adds over the previous generation: parametrised address width and bank count, counted burst reads/writes, a CoCo halt handshake before taking the bus, overrun detection and a status byte.
- Sits between the SPI_slave byte interface and the SRAM pins. When the SPI side does not own the bus, it passes CoCo address and select through.

Parameters:
ADDR_W, 16, total SPI byte-address width; 9..24.
NUM_BANKS, 2, number of SRAM chip selects; power of 2, >=2. BANK_BITS = log2(NUM_BANKS).
WR_PULSE, 6, clock_50 cycles that m_we_n is held low per byte; >=2.
RD_WAIT, 3, clock_50 cycles from m_oe_n low to m_din sample; >=1.

Ports:
clock_50  in  1  system clock.
reset  in  1  asynchronous, active-low.
spi_rx_valid  in  1  one-cycle strobe: spi_rx_data is valid.
spi_rx_data  in  8  byte received from SPI.
spi_tx_load  out  1  one-cycle strobe: load spi_tx_data into the SPI shifter.
spi_tx_data  out  8  byte to send.
c_addr  in  ADDR_W-BANK_BITS  CoCo SRAM address.
c_bank  in  BANK_BITS  CoCo bank select.
c_sel  in  1  CoCo SRAM access active.
c_rw  in  1  1 = CoCo read.
c_halt_req  out  1  request that the CoCo halt.
c_halt_ack  in  1  CoCo halted (synchronised externally).
m_addr  out  ADDR_W-BANK_BITS  SRAM address.
m_cs_n  out  NUM_BANKS  one-hot-low chip selects.
m_oe_n  out  1  SRAM output enable.
m_we_n  out  1  SRAM write enable.
m_dout  out  8  write data.
m_dout_en  out  1  drive the SRAM data bus.
m_din  in  8  SRAM read data.
spi_control  out  1  SPI side owns the SRAM bus.

Behaviour:
- Reset values:
  - state IDLE; addr 0; count 0; err 0; spi_control 0; c_halt_req 0.
  - m_we_n 1, m_oe_n 1, m_dout_en 0, spi_tx_load 0, spi_tx_data 0.
- Address bytes: AB = ceil(ADDR_W/8). Addresses are sent MSB first and the top bits are truncated. The address wraps modulo 2^ADDR_W.
- Bus mapping:
  - Bank = addr[ADDR_W-1 -: BANK_BITS]; m_addr = addr low bits.
  - spi_control=0: m_addr = c_addr; m_cs_n[c_bank] = ~c_sel; m_oe_n = ~(c_sel & c_rw); m_we_n 1; m_dout_en 0. This path is combinational.
- Commands, taken in IDLE only:
  - 0x01: enter ADDR and collect AB bytes.
  - 0x02: WCNT.
  - 0x03: RCNT.
  - 0x04: ACQ; raise c_halt_req.
  - 0x05: release; spi_control 0 and c_halt_req 0 next cycle.
  - 0x06: status; spi_tx_data = {spi_control, c_halt_req, err, 5'b0} with a spi_tx_load pulse; reading status clears err.
  - Any other value is ignored.
- ACQ: stay while c_halt_ack=0 or c_sel=1. When c_halt_ack=1 and c_sel=0, set spi_control=1 and return to IDLE. A command byte arriving in ACQ is dropped and sets err.
- Count byte: 0 means 256.
- Write burst:
  - If spi_control=0, data bytes are consumed and discarded and err=1.
  - Otherwise each data byte drives m_dout with m_dout_en=1 and m_we_n=0 for WR_PULSE cycles.
  - m_cs_n is active from the byte's cycle until one cycle after m_we_n rises. Then addr++ and count--.
  - A byte that arrives while the pulse is active is dropped, sets err, and is still counted.
  - Count reaching 0 returns to IDLE.
- Read burst:
  - After the count byte: assert m_oe_n=0 and chip select, wait RD_WAIT cycles, latch m_din into spi_tx_data, pulse spi_tx_load, deassert m_oe_n, then wait for spi_rx_valid (dummy byte).
  - On the dummy byte: addr++, count--, then fetch the next byte or return to IDLE at 0.
  - If spi_control=0: spi_tx_data=0xFF, err=1, no SRAM access.
- Simultaneous events: spi_rx_valid during a fetch sets err and the byte is treated as the dummy (early advance).
- Reset mid-operation aborts immediately. The bus is returned to the CoCo and no partial write pulse continues.

Test Plan:
1. Reset -> all outputs at reset values, spi_control=0; c_sel=1, c_rw=1, c_bank=1, c_addr=0x0123 -> m_cs_n=2'b01, m_oe_n=0, m_addr=0x0123.
2. Acquire: 0x04 with c_halt_ack=0 -> c_halt_req=1, spi_control=0 for 50 cycles; then ack=1 -> spi_control=1 within 2 cycles.
3. Write burst: 0x01 0x80 0x10, 0x02 0x03, data 0xAA 0xBB 0xCC spaced 20 cycles -> three m_we_n pulses of exactly 6 cycles, m_cs_n=2'b01, m_addr 0x0010/11/12, final addr 0x8013.
4. Read burst: 0x01 0xFF 0xFF, 0x03 0x02, model preloaded 0x5A@0xFFFF and 0xA5@0x0000 -> spi_tx_data 0x5A then 0xA5 after the dummy byte; addr wraps to 0x0000 and the bank switches to 0.
5. Overrun/error: write burst with the second data byte 2 cycles after the first -> one write only, status 0x06 returns 0xE0 and then 0xC0 on a second read.
6. Write 0x02 0x01 0x77 with spi_control=0 -> no m_we_n pulse, err set; assert reset during a write pulse -> m_we_n=1 and spi_control=0 within the same cycle.
